// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order frame reorder using ping-pong RAM banks; emits each frame as one gap-free burst.
// Latency: first output 3 edges after a frame's last input; no backpressure (input never stalled, output never stalls).
module fft_bitrev_reorder #(
    parameter int float_len     = 32,
    parameter int bram_addr_len = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [float_len*2-1:0]   data_in,
    input  logic                     data_in_valid,
    output logic [float_len*2-1:0]   data_out,
    output logic                     data_out_valid,
    output logic                     data_out_sop,
    output logic                     data_out_eop
);

    localparam int dw      = float_len * 2;
    localparam int n_words = 1 << bram_addr_len;
    localparam logic [bram_addr_len-1:0] last_idx = {bram_addr_len{1'b1}};

    typedef enum logic {IDLE, READ} state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic [bram_addr_len-1:0] wr_cnt;
    logic                     wr_bank;
    logic                     frame_done;

    logic [bram_addr_len-1:0] rd_cnt;
    logic [bram_addr_len-1:0] rd_cnt_nxt;
    logic                     rd_bank;
    logic                     rd_bank_nxt;
    logic                     rd_busy;
    logic                     rd_last;
    logic [bram_addr_len-1:0] rd_addr_rev;

    logic [dw-1:0]            mem [0:2*n_words-1];

    logic [bram_addr_len:0]   rd_addr;
    logic                     addr_vld;
    logic                     addr_sop;
    logic                     addr_eop;

    logic [dw-1:0]            ram_dat;
    logic                     ram_vld;
    logic                     ram_sop;
    logic                     ram_eop;

    assign frame_done = data_in_valid && (wr_cnt == last_idx);

    // Write side: the bank toggles on the same edge that stores the last word of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (data_in_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (frame_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (data_in_valid) begin
            mem[{wr_bank, wr_cnt}] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (frame_done) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if ((rd_cnt == last_idx) && !frame_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new frame restarts the read counter only when idle or on the final read of
    // the current frame, which is the only point a full bank can complete while reading.
    always_comb begin
        rd_busy     = (state == READ);
        rd_last     = rd_busy && (rd_cnt == last_idx);
        rd_cnt_nxt  = rd_cnt;
        rd_bank_nxt = rd_bank;
        if (frame_done && (!rd_busy || rd_last)) begin
            rd_cnt_nxt  = '0;
            rd_bank_nxt = wr_bank;
        end else if (rd_busy) begin
            rd_cnt_nxt = rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            rd_cnt  <= rd_cnt_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    always_comb begin
        rd_addr_rev = '0;
        for (int i = 0; i < bram_addr_len; i++) begin
            rd_addr_rev[i] = rd_cnt[bram_addr_len-1-i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr  <= '0;
            addr_vld <= 1'b0;
            addr_sop <= 1'b0;
            addr_eop <= 1'b0;
        end else begin
            rd_addr  <= {rd_bank, rd_addr_rev};
            addr_vld <= rd_busy;
            addr_sop <= rd_busy && (rd_cnt == '0);
            addr_eop <= rd_last;
        end
    end

    always_ff @(posedge clk) begin
        ram_dat <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_vld <= 1'b0;
            ram_sop <= 1'b0;
            ram_eop <= 1'b0;
        end else begin
            ram_vld <= addr_vld;
            ram_sop <= addr_sop;
            ram_eop <= addr_eop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_out_sop   <= 1'b0;
            data_out_eop   <= 1'b0;
        end else begin
            data_out       <= ram_vld ? ram_dat : '0;
            data_out_valid <= ram_vld;
            data_out_sop   <= ram_vld && ram_sop;
            data_out_eop   <= ram_vld && ram_eop;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: an 8-point instance and a default 8192-point instance,
// each checked cycle by cycle against a frame-level reorder model.
module tb_fft_bitrev_reorder;

    localparam int SL = 3;
    localparam int NS = 1 << SL;
    localparam int BL = 13;
    localparam int NB = 1 << BL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_din = '0;
    logic        s_vld = 1'b0;
    logic [63:0] b_din = '0;
    logic        b_vld = 1'b0;
    logic [63:0] s_dout, b_dout;
    logic        s_ov, s_sop, s_eop, b_ov, b_sop, b_eop;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.float_len(32), .bram_addr_len(SL)) dut_s (
        .clk(clk), .rst(rst), .data_in(s_din), .data_in_valid(s_vld),
        .data_out(s_dout), .data_out_valid(s_ov), .data_out_sop(s_sop), .data_out_eop(s_eop)
    );

    fft_bitrev_reorder dut_b (
        .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_vld),
        .data_out(b_dout), .data_out_valid(b_ov), .data_out_sop(b_sop), .data_out_eop(b_eop)
    );

    typedef struct {
        int          cyc;
        logic [63:0] dat;
        bit          sop;
        bit          eop;
    } ev_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [63:0] s_frame[$];
    logic [63:0] b_frame[$];
    ev_t         s_exp[$];
    ev_t         b_exp[$];
    ev_t         s_obs[$];
    ev_t         b_obs[$];
    int          s_done[$];
    ev_t         me_s, me_b, ce_s, ce_b;

    function automatic int bitrev(input int k, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            if (((k >> i) & 1) != 0) r |= 1 << (w - 1 - i);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a complete frame of N inputs leaves as N outputs in bit-reversed
    // position order, starting 3 edges after its last input edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && s_vld) begin
            s_frame.push_back(s_din);
            if (s_frame.size() == NS) begin
                s_done.push_back(cyc);
                for (int k = 0; k < NS; k++) begin
                    me_s.cyc = cyc + 3 + k;
                    me_s.dat = s_frame[bitrev(k, SL)];
                    me_s.sop = (k == 0);
                    me_s.eop = (k == NS - 1);
                    s_exp.push_back(me_s);
                end
                s_frame.delete();
            end
        end
        if (!rst && b_vld) begin
            b_frame.push_back(b_din);
            if (b_frame.size() == NB) begin
                for (int k = 0; k < NB; k++) begin
                    me_b.cyc = cyc + 3 + k;
                    me_b.dat = b_frame[bitrev(k, BL)];
                    me_b.sop = (k == 0);
                    me_b.eop = (k == NB - 1);
                    b_exp.push_back(me_b);
                end
                b_frame.delete();
            end
        end
    end

    always @(posedge rst) begin
        s_frame.delete();
        b_frame.delete();
        s_exp.delete();
        b_exp.delete();
    end

    always @(negedge clk) begin
        if (s_exp.size() > 0 && s_exp[0].cyc == cyc) begin
            ce_s = s_exp.pop_front();
            chk("s_valid", s_ov, 1);
            chk("s_data", s_dout, ce_s.dat);
            chk("s_sop_eop", {s_sop, s_eop}, {ce_s.sop, ce_s.eop});
        end else begin
            chk("s_idle_flags", {s_ov, s_sop, s_eop}, 0);
            chk("s_idle_data", s_dout, 0);
        end
        if (b_exp.size() > 0 && b_exp[0].cyc == cyc) begin
            ce_b = b_exp.pop_front();
            chk("b_valid", b_ov, 1);
            chk("b_data", b_dout, ce_b.dat);
            chk("b_sop_eop", {b_sop, b_eop}, {ce_b.sop, ce_b.eop});
        end else begin
            chk("b_idle_flags", {b_ov, b_sop, b_eop}, 0);
            chk("b_idle_data", b_dout, 0);
        end
        if (s_ov) s_obs.push_back('{cyc, s_dout, s_sop, s_eop});
        if (b_ov) b_obs.push_back('{cyc, b_dout, b_sop, b_eop});
        if (dut_s.frame_done && dut_s.rd_busy) chk("s_frame_done_in_read", dut_s.rd_cnt, NS - 1);
        if (dut_b.frame_done && dut_b.rd_busy) chk("b_frame_done_in_read", dut_b.rd_cnt, NB - 1);
    end

    task automatic drv(input bit big, input bit v, input logic [63:0] d);
        @(posedge clk);
        #1;
        if (big) begin
            b_vld = v;
            b_din = d;
        end else begin
            s_vld = v;
            s_din = d;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            s_vld = 1'b0;
            s_din = {$urandom, $urandom};
            b_vld = 1'b0;
            b_din = {$urandom, $urandom};
        end
    endtask

    task automatic wait_obs(input bit big, input int n, input int budget);
        int i = 0;
        while (((big ? b_obs.size() : s_obs.size()) < n) && i < budget) begin
            @(negedge clk);
            i++;
        end
        repeat (6) @(negedge clk);
        chk(big ? "b_output_count" : "s_output_count", big ? b_obs.size() : s_obs.size(), n);
    endtask

    task automatic check_lit(input string tag, input logic [63:0] vals[$]);
        if (s_obs.size() >= vals.size() && s_done.size() > 0) begin
            chk({tag, "_latency"}, s_obs[0].cyc, s_done[0] + 3);
            for (int k = 0; k < vals.size(); k++) begin
                chk({tag, "_data"}, s_obs[k].dat, vals[k]);
                chk({tag, "_gapfree"}, s_obs[k].cyc - s_obs[0].cyc, k);
                chk({tag, "_sop"}, s_obs[k].sop, (k % NS) == 0);
                chk({tag, "_eop"}, s_obs[k].eop, (k % NS) == NS - 1);
            end
        end
    endtask

    task automatic start_test();
        s_obs.delete();
        b_obs.delete();
        s_done.delete();
    endtask

    initial begin
        logic [63:0] lit[$];
        int sop_n, eop_n;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            s_vld = 1'($urandom);
            s_din = {$urandom, $urandom};
            b_vld = 1'($urandom);
            b_din = {$urandom, $urandom};
        end
        chk("reset_outputs", {s_ov, s_sop, s_eop, b_ov, b_sop, b_eop}, 0);
        chk("reset_data", s_dout | b_dout, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        s_vld = 1'b0;
        b_vld = 1'b0;
        idle(4);
        for (int i = 0; i < NS - 1; i++) drv(0, 1, 64'(i + 500));
        idle(10);
        chk("no_output_before_full_frame", s_obs.size(), 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);

        start_test();
        for (int i = 0; i < NS; i++) drv(0, 1, 64'(i));
        idle(1);
        wait_obs(0, NS, 40);
        lit = '{64'd0, 64'd4, 64'd2, 64'd6, 64'd1, 64'd5, 64'd3, 64'd7};
        check_lit("contig", lit);

        start_test();
        for (int i = 0; i < NS; i++) begin
            drv(0, 1, 64'(i));
            idle(2);
        end
        wait_obs(0, NS, 40);
        check_lit("sparse", lit);

        start_test();
        for (int i = 0; i < 2 * NS; i++) drv(0, 1, 64'(i));
        idle(1);
        wait_obs(0, 2 * NS, 60);
        lit = '{64'd0, 64'd4, 64'd2, 64'd6, 64'd1, 64'd5, 64'd3, 64'd7,
                64'd8, 64'd12, 64'd10, 64'd14, 64'd9, 64'd13, 64'd11, 64'd15};
        check_lit("b2b", lit);

        start_test();
        for (int i = 0; i < 5; i++) drv(0, 1, 64'(i + 50));
        idle(1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < NS; i++) drv(0, 1, 64'(i + 100));
        idle(1);
        wait_obs(0, NS, 40);
        lit = '{64'd100, 64'd104, 64'd102, 64'd106, 64'd101, 64'd105, 64'd103, 64'd107};
        check_lit("midreset", lit);

        start_test();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NS; i++) begin
                drv(0, 1, {$urandom, $urandom});
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 12));
        end
        idle(1);
        wait_obs(0, 6 * NS, 400);

        start_test();
        for (int i = 0; i < 2 * NB; i++) drv(1, 1, 64'(i));
        idle(1);
        wait_obs(1, 2 * NB, 2 * NB + 50);
        if (b_obs.size() == 2 * NB) begin
            sop_n = 0;
            eop_n = 0;
            foreach (b_obs[k]) begin
                sop_n += int'(b_obs[k].sop);
                eop_n += int'(b_obs[k].eop);
            end
            chk("big_sop_count", sop_n, 2);
            chk("big_eop_count", eop_n, 2);
            chk("big_continuous", b_obs[2 * NB - 1].cyc - b_obs[0].cyc, 2 * NB - 1);
            chk("big_out1", b_obs[1].dat, 64'd4096);
            chk("big_out2", b_obs[2].dat, 64'd2048);
            chk("big_out3", b_obs[3].dat, 64'd6144);
            chk("big_out8191", b_obs[NB - 1].dat, 64'd8191);
            chk("big_out8192", b_obs[NB].dat, 64'd8192);
            chk("big_out8193", b_obs[NB + 1].dat, 64'd12288);
        end

        idle(10);
        chk("s_model_drained", s_exp.size(), 0);
        chk("b_model_drained", b_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
